dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer for the single-port data memory (word-indexed, combinational read, negedge write, funct3-driven store merge and load extension). It shares the memory between the core load/store port (port 0) and a DMA/loader port (port 1). It accepts one access per cycle, drives the memory control bus from a registered command stage, and returns registered read data with a completion pulse to the winning port. Illegal accesses are rejected before they reach the memory.

## Interface
Parameters:
- DEPTH, 1024, number of memory words; word index is the full `addr` value.
- STARVE_LIMIT, 4, consecutive cycles port 1 may request while losing before it is forced to win.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low; sampled on rising edge of clk.
- req0, req1  in  1  access request; held with its fields stable until `gntN`.
- we0, we1  in  1  1 = store, 0 = load.
- addr0, addr1  in  32  word index.
- wdata0, wdata1  in  32  store data.
- funct3_0, funct3_1  in  3  RV32 load/store funct3.
- gnt0, gnt1  out  1  combinational; request accepted this cycle.
- done0, done1  out  1  one-cycle completion pulse.
- err0, err1  out  1  valid with `doneN`; access rejected, memory untouched.
- rdata  out  32  load result, valid with `done0`/`done1` on loads.
- mem_WE, mem_RE  out  1  memory write and read enables.
- mem_A  out  32  memory address.
- mem_WD  out  32  memory write data.
- mem_funct3  out  3  memory funct3.
- mem_RD  in  32  memory read data (already extended).

## Operation
- **Pipeline stages.** A0 (arbitrate and accept) → A1 (command register drives memory) → A2 (response register drives done/rdata).
- **Arbitration.** Each cycle, port 0 wins if `req0` is high. Exception: port 1 wins if `req1` is high and `starve_cnt == STARVE_LIMIT`. Port 1 also wins if `req1` is high and `req0` is low. At most one `gnt` is high per cycle.
- **starve_cnt (width `clog2(STARVE_LIMIT+1)`).**
  - Increments, saturating, when `req1` is high and not granted.
  - Clears when `gnt1` is high or `req1` is low.
- **Legality check (in A0).**
  - Store: funct3 must be in {000, 001, 010}.
  - Load: funct3 must be in {000, 001, 010, 100, 101}.
  - `addr` must be < DEPTH.
  - An illegal access is still granted. It enters A1 as a bubble (`mem_WE = mem_RE = 0`) with its error flag set.
- **A1 (command valid and legal).**
  - `mem_A = addr`, `mem_funct3 = funct3`.
  - Store: `mem_WE = 1`, `mem_WD = wdata`, `mem_RE = 0`.
  - Load: `mem_RE = 1`, `mem_WE = 0`, `mem_WD = 0`.
- **A1 idle or bubble.** `mem_WE = 0`, `mem_RE = 0`, `mem_A = 0`, `mem_WD = 0`, `mem_funct3 = 3'b010`.
- **A2 capture.** At the end of A1:
  - `rdata` loads `mem_RD` for a legal load.
  - `rdata` loads 0 for a store or error.
  - The port tag and err flag are captured alongside.
  - `doneN` pulses for the tagged port only.
- **Reset (rst = 0).** A1 and A2 are invalidated, `starve_cnt` clears, and all outputs take their reset values. An in-flight access produces no `done`. A store in A1 during the reset cycle must not reach memory, because `mem_WE` is forced to 0 combinationally while `rst = 0`.

## Timing
- Request accepted in cycle N (`gntN` high in N).
- Memory bus driven in cycle N+1; the store commits on the falling edge within N+1.
- `doneN`, `errN` and `rdata` are valid in cycle N+2 for exactly one cycle.
- Throughput is one access per cycle. Back-to-back grants are allowed, including alternating ports.
- **Store-then-load, same address, consecutive grants.** The load in A1 at N+2 observes the new data. No forwarding is needed.
- **Reset values.** `gnt0`, `gnt1`, `done0`, `done1`, `err0`, `err1`, `mem_WE`, `mem_RE` = 0. `rdata`, `mem_A`, `mem_WD` = 0. `mem_funct3` = 3'b010.
- **gnt during reset.** `gnt*` is held 0 while `rst = 0`, even if requests are present.
- `rdata` holds its last value between `done` pulses; it changes only on A2 capture.
- A requester may deassert `req` or change fields in the cycle after `gnt`. No other input is sampled.

## Test plan
- **Single load.** Memory word 5 = 0x00000085. Port 0 issues a load with addr=5, funct3=000.
  - `gnt0` in cycle N; `mem_RE = 1` and `mem_A = 5` in N+1.
  - `done0 = 1`, `rdata = 0xFFFFFF85`, `err0 = 0` in N+2.
- **Back-to-back store then load, same address.** Port 1 stores 0xDEADBEEF to addr 7 (SW), then loads addr 7 (LW) on the next grant.
  - `done1` pulses twice in consecutive cycles.
  - The second pulse carries `rdata = 0xDEADBEEF`.
- **Starvation.** `req0` and `req1` held high continuously with STARVE_LIMIT=4.
  - Grant sequence: `gnt0` ×4, then `gnt1`, then `gnt0` ×4, repeating.
  - `starve_cnt` returns to 0 after each `gnt1`.
- **Illegal access.** Port 0 issues a store with funct3=100; port 1 issues a load with addr=1024.
  - Each is granted, with `mem_WE = mem_RE = 0` in its A1 cycle.
  - `done` arrives with `err = 1` and `rdata = 0`; memory contents are unchanged.
- **Reset mid-operation.** Port 0 store (addr=3, data=0x11) is granted in N; `rst = 0` in N+1.
  - `mem_WE = 0` in N+1; no `done0` is produced.
  - Word 3 keeps its prior value; all outputs are at their reset values in N+2.
- **Simultaneous requests, port 0 idle afterwards.** `req0` and `req1` high in one cycle, then only `req1`.
  - `gnt0` first, then `gnt1`.
  - `done0` and `done1` pulse in consecutive cycles, in the same order.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and three-stage access sequencer for a single-port data memory.
// Port 0 (core) has priority. Port 1 (DMA/loader) is forced through after STARVE_LIMIT lost cycles.
module dmem_arbiter #(
    parameter int DEPTH        = 1024,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [2:0]  funct3_0,
    input  logic [2:0]  funct3_1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata,
    output logic        mem_WE,
    output logic        mem_RE,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_RD
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [1:0]       we_v;
    logic [1:0][31:0] addr_v;
    logic [1:0][31:0] wdata_v;
    logic [1:0][2:0]  funct3_v;
    logic [1:0]       legal_v;

    assign we_v     = {we1, we0};
    assign addr_v   = {addr1, addr0};
    assign wdata_v  = {wdata1, wdata0};
    assign funct3_v = {funct3_1, funct3_0};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_legal
            logic f3_ok;
            always_comb begin
                f3_ok = 1'b0;
                if (we_v[gi]) begin
                    f3_ok = (funct3_v[gi] == 3'b000) || (funct3_v[gi] == 3'b001) ||
                            (funct3_v[gi] == 3'b010);
                end else begin
                    f3_ok = (funct3_v[gi] == 3'b000) || (funct3_v[gi] == 3'b001) ||
                            (funct3_v[gi] == 3'b010) || (funct3_v[gi] == 3'b100) ||
                            (funct3_v[gi] == 3'b101);
                end
            end
            assign legal_v[gi] = f3_ok && (addr_v[gi] < 32'(DEPTH));
        end
    endgenerate

    // ---------------- A0: arbitration ----------------
    logic [CW-1:0] starve_cnt_reg, starve_cnt_next;
    logic          force1;

    always_comb begin
        force1 = req1 && (starve_cnt_reg == CW'(STARVE_LIMIT));
        gnt1   = rst && req1 && (!req0 || force1);
        gnt0   = rst && req0 && !gnt1;

        starve_cnt_next = starve_cnt_reg;
        if (!req1 || gnt1) begin
            starve_cnt_next = '0;
        end else if (starve_cnt_reg != CW'(STARVE_LIMIT)) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    // ---------------- A1: command register ----------------
    logic        a1_valid_reg, a1_port_reg, a1_we_reg, a1_err_reg;
    logic [31:0] a1_addr_reg, a1_wdata_reg;
    logic [2:0]  a1_funct3_reg;
    logic        sel;

    assign sel = gnt1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt_reg <= '0;
            a1_valid_reg   <= 1'b0;
            a1_port_reg    <= 1'b0;
            a1_we_reg      <= 1'b0;
            a1_err_reg     <= 1'b0;
            a1_addr_reg    <= '0;
            a1_wdata_reg   <= '0;
            a1_funct3_reg  <= 3'b010;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            a1_valid_reg   <= gnt0 || gnt1;
            a1_port_reg    <= sel;
            a1_we_reg      <= we_v[sel];
            a1_err_reg     <= !legal_v[sel];
            a1_addr_reg    <= addr_v[sel];
            a1_wdata_reg   <= wdata_v[sel];
            a1_funct3_reg  <= funct3_v[sel];
        end
    end

    // Gating with rst keeps a store sitting in A1 during a reset cycle off the memory.
    logic cmd_live;
    assign cmd_live = rst && a1_valid_reg && !a1_err_reg;

    always_comb begin
        mem_WE     = 1'b0;
        mem_RE     = 1'b0;
        mem_A      = '0;
        mem_WD     = '0;
        mem_funct3 = 3'b010;
        if (cmd_live) begin
            mem_A      = a1_addr_reg;
            mem_funct3 = a1_funct3_reg;
            if (a1_we_reg) begin
                mem_WE = 1'b1;
                mem_WD = a1_wdata_reg;
            end else begin
                mem_RE = 1'b1;
            end
        end
    end

    // ---------------- A2: response register ----------------
    logic        a2_valid_reg, a2_port_reg, a2_err_reg;
    logic [31:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            a2_valid_reg <= 1'b0;
            a2_port_reg  <= 1'b0;
            a2_err_reg   <= 1'b0;
            rdata_reg    <= '0;
        end else begin
            a2_valid_reg <= a1_valid_reg;
            if (a1_valid_reg) begin
                a2_port_reg <= a1_port_reg;
                a2_err_reg  <= a1_err_reg;
                rdata_reg   <= (cmd_live && !a1_we_reg) ? mem_RD : 32'h0;
            end
        end
    end

    assign done0 = a2_valid_reg && !a2_port_reg;
    assign done1 = a2_valid_reg && a2_port_reg;
    assign err0  = done0 && a2_err_reg;
    assign err1  = done1 && a2_err_reg;
    assign rdata = rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a local word-indexed memory model
// (combinational read with load extension, negedge write with store merge).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [2:0]  funct3_0, funct3_1;
    logic        gnt0, gnt1, done0, done1, err0, err1;
    logic [31:0] rdata;
    logic        mem_WE, mem_RE;
    logic [31:0] mem_A, mem_WD, mem_RD;
    logic [2:0]  mem_funct3;

    int checks   = 0;
    int failures = 0;

    logic [31:0] tb_mem [0:1023];

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH(1024), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .funct3_0(funct3_0), .funct3_1(funct3_1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1), .rdata(rdata),
        .mem_WE(mem_WE), .mem_RE(mem_RE), .mem_A(mem_A), .mem_WD(mem_WD),
        .mem_funct3(mem_funct3), .mem_RD(mem_RD)
    );

    // Memory model
    always_comb begin
        logic [31:0] w;
        w = (mem_A < 32'd1024) ? tb_mem[mem_A[9:0]] : 32'h0;
        case (mem_funct3)
            3'b000:  mem_RD = {{24{w[7]}}, w[7:0]};
            3'b001:  mem_RD = {{16{w[15]}}, w[15:0]};
            3'b100:  mem_RD = {24'h0, w[7:0]};
            3'b101:  mem_RD = {16'h0, w[15:0]};
            default: mem_RD = w;
        endcase
    end

    always @(negedge clk) begin
        if (mem_WE && mem_A < 32'd1024) begin
            case (mem_funct3)
                3'b000:  tb_mem[mem_A[9:0]][7:0]  = mem_WD[7:0];
                3'b001:  tb_mem[mem_A[9:0]][15:0] = mem_WD[15:0];
                default: tb_mem[mem_A[9:0]]       = mem_WD;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        funct3_0 = 3'b010; funct3_1 = 3'b010;
    endtask

    task automatic test_reset();
        rst = 0;
        idle_inputs();
        req0 = 1; req1 = 1;
        step(); step();
        #2;
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%b%b exp=00", gnt0, gnt1); end
        checks++; if ({done0, done1, err0, err1} !== 4'b0) begin failures++; $display("FAIL reset_done got=%b exp=0000", {done0, done1, err0, err1}); end
        checks++; if (mem_WE !== 1'b0 || mem_RE !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%b%b exp=00", mem_WE, mem_RE); end
        checks++; if (rdata !== 32'h0 || mem_A !== 32'h0 || mem_WD !== 32'h0) begin failures++; $display("FAIL reset_data rdata=%h A=%h WD=%h exp=0", rdata, mem_A, mem_WD); end
        checks++; if (mem_funct3 !== 3'b010) begin failures++; $display("FAIL reset_funct3 got=%b exp=010", mem_funct3); end
        idle_inputs();
        rst = 1;
        step(); step();
        $display("reset: outputs checked with requests present");
    endtask

    task automatic test_single_load();
        req0 = 1; we0 = 0; addr0 = 5; funct3_0 = 3'b000;
        #2;
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin failures++; $display("FAIL load_gnt got=%b%b exp=10", gnt0, gnt1); end
        step();
        idle_inputs();
        #2;
        checks++; if (mem_RE !== 1'b1 || mem_WE !== 1'b0 || mem_A !== 32'd5) begin failures++; $display("FAIL load_a1 RE=%b WE=%b A=%h exp RE=1 WE=0 A=5", mem_RE, mem_WE, mem_A); end
        checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL load_early_done got=%b exp=0", done0); end
        step();
        #2;
        checks++; if (done0 !== 1'b1 || err0 !== 1'b0 || done1 !== 1'b0) begin failures++; $display("FAIL load_done done0=%b err0=%b done1=%b exp 1 0 0", done0, err0, done1); end
        checks++; if (rdata !== 32'hFFFFFF85) begin failures++; $display("FAIL load_rdata got=%h exp=ffffff85", rdata); end
        step();
        #2;
        checks++; if (done0 !== 1'b0 || rdata !== 32'hFFFFFF85) begin failures++; $display("FAIL load_hold done0=%b rdata=%h exp 0 ffffff85", done0, rdata); end
        $display("single_load: port0 LB addr=5 rdata=%h", rdata);
    endtask

    task automatic test_back_to_back();
        req1 = 1; we1 = 1; addr1 = 7; wdata1 = 32'hDEADBEEF; funct3_1 = 3'b010;
        #2;
        checks++; if (gnt1 !== 1'b1) begin failures++; $display("FAIL b2b_gnt_store got=%b exp=1", gnt1); end
        step();
        we1 = 0; wdata1 = 0;
        #2;
        checks++; if (gnt1 !== 1'b1) begin failures++; $display("FAIL b2b_gnt_load got=%b exp=1", gnt1); end
        checks++; if (mem_WE !== 1'b1 || mem_WD !== 32'hDEADBEEF || mem_A !== 32'd7) begin failures++; $display("FAIL b2b_store_bus WE=%b WD=%h A=%h exp 1 deadbeef 7", mem_WE, mem_WD, mem_A); end
        step();
        idle_inputs();
        #2;
        checks++; if (mem_RE !== 1'b1 || mem_A !== 32'd7) begin failures++; $display("FAIL b2b_load_bus RE=%b A=%h exp 1 7", mem_RE, mem_A); end
        checks++; if (done1 !== 1'b1 || err1 !== 1'b0 || rdata !== 32'h0) begin failures++; $display("FAIL b2b_done_store done1=%b err1=%b rdata=%h exp 1 0 0", done1, err1, rdata); end
        step();
        #2;
        checks++; if (done1 !== 1'b1 || rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL b2b_done_load done1=%b rdata=%h exp 1 deadbeef", done1, rdata); end
        step();
        #2;
        checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL b2b_done_end got=%b exp=0", done1); end
        checks++; if (tb_mem[7] !== 32'hDEADBEEF) begin failures++; $display("FAIL b2b_mem7 got=%h exp=deadbeef", tb_mem[7]); end
        $display("back_to_back: port1 SW/LW addr=7 rdata=%h", rdata);
    endtask

    task automatic test_starvation();
        req0 = 1; we0 = 0; addr0 = 5; funct3_0 = 3'b000;
        req1 = 1; we1 = 0; addr1 = 5; funct3_1 = 3'b000;
        for (int i = 0; i < 15; i++) begin
            #2;
            checks++;
            if (gnt1 !== ((i % 5) == 4) || gnt0 !== ((i % 5) != 4)) begin
                failures++;
                $display("FAIL starve_gnt cycle=%0d got=%b%b exp=%b%b", i, gnt0, gnt1, (i % 5) != 4, (i % 5) == 4);
            end
            checks++;
            if (int'(dut.starve_cnt_reg) !== (i % 5)) begin
                failures++;
                $display("FAIL starve_cnt cycle=%0d got=%0d exp=%0d", i, dut.starve_cnt_reg, i % 5);
            end
            step();
        end
        idle_inputs();
        step(); step(); step();
        $display("starvation: 15 cycles, port1 forced every 5th");
    endtask

    task automatic test_reset_mid();
        tb_mem[3] = 32'h000000AA;
        req0 = 1; we0 = 1; addr0 = 3; wdata0 = 32'h11; funct3_0 = 3'b010;
        #2;
        checks++; if (gnt0 !== 1'b1) begin failures++; $display("FAIL rstmid_gnt got=%b exp=1", gnt0); end
        step();
        idle_inputs();
        rst = 0;
        #2;
        checks++; if (mem_WE !== 1'b0) begin failures++; $display("FAIL rstmid_we got=%b exp=0", mem_WE); end
        step();
        rst = 1;
        #2;
        checks++; if (done0 !== 1'b0 || done1 !== 1'b0 || err0 !== 1'b0) begin failures++; $display("FAIL rstmid_done done0=%b done1=%b err0=%b exp 000", done0, done1, err0); end
        checks++; if (rdata !== 32'h0 || mem_RE !== 1'b0 || mem_A !== 32'h0 || mem_funct3 !== 3'b010) begin failures++; $display("FAIL rstmid_outs rdata=%h RE=%b A=%h f3=%b", rdata, mem_RE, mem_A, mem_funct3); end
        #5;
        checks++; if (tb_mem[3] !== 32'h000000AA) begin failures++; $display("FAIL rstmid_mem3 got=%h exp=000000aa", tb_mem[3]); end
        step();
        $display("reset_mid: store to addr=3 squashed");
    endtask

    task automatic test_simultaneous();
        req0 = 1; we0 = 0; addr0 = 5; funct3_0 = 3'b100;
        req1 = 1; we1 = 0; addr1 = 7; funct3_1 = 3'b001;
        #2;
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin failures++; $display("FAIL simul_first got=%b%b exp=10", gnt0, gnt1); end
        step();
        req0 = 0;
        #2;
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin failures++; $display("FAIL simul_second got=%b%b exp=01", gnt0, gnt1); end
        step();
        idle_inputs();
        #2;
        checks++; if (done0 !== 1'b1 || done1 !== 1'b0 || rdata !== 32'h00000085) begin failures++; $display("FAIL simul_done0 done=%b%b rdata=%h exp 10 00000085", done0, done1, rdata); end
        step();
        #2;
        checks++; if (done0 !== 1'b0 || done1 !== 1'b1 || rdata !== 32'hFFFFBEEF) begin failures++; $display("FAIL simul_done1 done=%b%b rdata=%h exp 01 ffffbeef", done0, done1, rdata); end
        step();
        $display("simultaneous: LBU p0 then LH p1 rdata=%h", rdata);
    endtask

    task automatic test_illegal();
        tb_mem[20] = 32'h12345678;
        req0 = 1; we0 = 1; addr0 = 20; wdata0 = 32'hCAFEF00D; funct3_0 = 3'b100;
        req1 = 1; we1 = 0; addr1 = 1024; funct3_1 = 3'b010;
        #2;
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin failures++; $display("FAIL illegal_gnt0 got=%b%b exp=10", gnt0, gnt1); end
        step();
        req0 = 0;
        #2;
        checks++; if (gnt1 !== 1'b1) begin failures++; $display("FAIL illegal_gnt1 got=%b exp=1", gnt1); end
        checks++; if (mem_WE !== 1'b0 || mem_RE !== 1'b0) begin failures++; $display("FAIL illegal_bubble0 WE=%b RE=%b exp 00", mem_WE, mem_RE); end
        step();
        idle_inputs();
        #2;
        checks++; if (mem_WE !== 1'b0 || mem_RE !== 1'b0) begin failures++; $display("FAIL illegal_bubble1 WE=%b RE=%b exp 00", mem_WE, mem_RE); end
        checks++; if (done0 !== 1'b1 || err0 !== 1'b1 || rdata !== 32'h0) begin failures++; $display("FAIL illegal_done0 done0=%b err0=%b rdata=%h exp 1 1 0", done0, err0, rdata); end
        step();
        #2;
        checks++; if (done1 !== 1'b1 || err1 !== 1'b1 || done0 !== 1'b0 || rdata !== 32'h0) begin failures++; $display("FAIL illegal_done1 done1=%b err1=%b done0=%b rdata=%h exp 1 1 0 0", done1, err1, done0, rdata); end
        step();
        #2;
        checks++; if (tb_mem[20] !== 32'h12345678) begin failures++; $display("FAIL illegal_mem20 got=%h exp=12345678", tb_mem[20]); end
        $display("illegal: p0 store f3=100, p1 load addr=1024 rejected");
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) tb_mem[i] = 32'h0;
        tb_mem[5] = 32'h00000085;
        test_reset();
        test_single_load();
        test_back_to_back();
        test_starvation();
        test_reset_mid();
        test_simultaneous();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
